// File: rtl/neuron_mac_seq.sv
// Sequential N-input neuron: streams (x, w) beats into a full-precision MAC, adds bias,
// then returns a synchronous sigmoid-ROM lookup or the saturated linear pre-activation.
module neuron_mac_seq #(
    parameter int N_INPUTS     = 4,
    parameter int LUT_AW       = 11,
    parameter int Z_RANGE_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [16:0]       bias,
    input  logic              act_bypass,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [16:0]       x,
    input  logic [16:0]       w,
    output logic [LUT_AW-1:0] lut_addr,
    input  logic [16:0]       lut_data,
    output logic [16:0]       y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);
    localparam int CW   = $clog2(N_INPUTS + 1);
    localparam int ACCW = 35 + $clog2(N_INPUTS);
    localparam int ZW   = ACCW + 1;
    localparam int SH   = 28 + Z_RANGE_LOG2 - (LUT_AW - 1);

    localparam logic signed [ZW-1:0] HALF_Z = ZW'(64'sd1 << (LUT_AW - 1));
    localparam logic signed [ZW-1:0] AMAX_Z = ZW'((64'sd1 << LUT_AW) - 64'sd1);
    localparam logic signed [ZW-1:0] YMAX_Z = ZW'(65535);
    localparam logic signed [ZW-1:0] YMIN_Z = ZW'(-65536);
    localparam logic [LUT_AW-1:0]    ADDR_RST = {1'b1, {(LUT_AW - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_ADDR,
        S_LUT,
        S_DONE
    } state_t;

    state_t                   state_q;
    logic [CW-1:0]            cnt_q;
    logic signed [ACCW-1:0]   acc_q;
    logic signed [33:0]       p_q;
    logic                     p_vld_q;
    logic [16:0]              bias_q;
    logic                     byp_q;
    logic signed [ZW-1:0]     z_q;
    logic                     ph_q;
    logic [LUT_AW-1:0]        lut_addr_q;
    logic [16:0]              yb_q;
    logic [16:0]              y_q;
    logic                     out_valid_q;
    logic                     in_ready_q;
    logic                     busy_q;

    logic                     beat;
    logic signed [33:0]       prod_d;
    logic signed [ACCW-1:0]   acc_d;
    logic signed [ZW-1:0]     z_d;
    logic signed [ZW-1:0]     sum_d;
    logic signed [ZW-1:0]     yt_d;
    logic [LUT_AW-1:0]        addr_d;
    logic [16:0]              yb_d;

    always_comb begin
        beat   = (state_q == S_ACCUM) && in_valid && in_ready_q;
        prod_d = $signed({{17{x[16]}}, x}) * $signed({{17{w[16]}}, w});
        acc_d  = acc_q + $signed({{(ACCW - 34){p_q[33]}}, p_q});
        z_d    = $signed({{(ZW - ACCW){acc_q[ACCW-1]}}, acc_q})
               + $signed({{(ZW - 33){bias_q[16]}}, bias_q, 16'b0});
        sum_d  = (z_q >>> SH) + HALF_Z;
        yt_d   = z_q >>> 16;

        if (sum_d[ZW-1]) begin
            addr_d = '0;
        end else if (sum_d > AMAX_Z) begin
            addr_d = '1;
        end else begin
            addr_d = sum_d[LUT_AW-1:0];
        end

        if (yt_d > YMAX_Z) begin
            yb_d = 17'h0FFFF;
        end else if (yt_d < YMIN_Z) begin
            yb_d = 17'h10000;
        end else begin
            yb_d = yt_d[16:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            p_vld_q     <= 1'b0;
            bias_q      <= '0;
            byp_q       <= 1'b0;
            z_q         <= '0;
            ph_q        <= 1'b0;
            lut_addr_q  <= ADDR_RST;
            yb_q        <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    p_vld_q <= 1'b0;
                    if (start) begin
                        bias_q     <= bias;
                        byp_q      <= act_bypass;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    // Products are registered first and folded into acc one cycle later.
                    if (p_vld_q) acc_q <= acc_d;
                    p_vld_q <= beat;
                    if (beat) begin
                        p_q   <= prod_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(N_INPUTS - 1)) begin
                            in_ready_q <= 1'b0;
                            state_q    <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (p_vld_q) acc_q <= acc_d;
                    p_vld_q <= 1'b0;
                    ph_q    <= 1'b0;
                    state_q <= S_ADDR;
                end
                S_ADDR: begin
                    // Two phases: the wide bias add is registered before shift/clamp.
                    if (!ph_q) begin
                        z_q  <= z_d;
                        ph_q <= 1'b1;
                    end else begin
                        lut_addr_q <= addr_d;
                        yb_q       <= yb_d;
                        state_q    <= S_LUT;
                    end
                end
                S_LUT: begin
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    if (!out_valid_q) begin
                        y_q         <= byp_q ? yb_q : lut_data;
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign lut_addr  = lut_addr_q;
    assign y         = y_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Scoreboard bench for neuron_mac_seq: three instances (default, N=8/LUT_AW=10/Z=4, N=1)
// driven with directed and random evaluations, checked against an integer reference model.
module tb_neuron_mac_seq;
    localparam int ND = 3;

    typedef struct {
        int dut;
        int y;
        int addr;
        int lastcyc;
        int hold;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st   [ND];
    logic        byp  [ND];
    logic        iv   [ND];
    logic        ordy [ND] = '{1'b0, 1'b0, 1'b0};
    logic [16:0] bias [ND];
    logic [16:0] xv   [ND];
    logic [16:0] wv   [ND];
    logic [16:0] ld   [ND];
    logic [ND-1:0] ir, ov, bz;
    logic [16:0] y0, y1, y2;
    logic [10:0] la0, la2;
    logic [9:0]  la1;

    exp_t sb[$];
    logic [16:0] xa [8];
    logic [16:0] wa [8];
    int ncmp = 0;
    int nerr = 0;
    int cyc = 0;
    int hold_cnt [ND] = '{0, 0, 0};
    logic prev_ov [ND] = '{1'b0, 1'b0, 1'b0};
    logic fall_chk [ND] = '{1'b0, 1'b0, 1'b0};
    int mon_k;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    neuron_mac_seq u0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .bias(bias[0]), .act_bypass(byp[0]),
        .in_valid(iv[0]), .in_ready(ir[0]), .x(xv[0]), .w(wv[0]), .lut_addr(la0),
        .lut_data(ld[0]), .y(y0), .out_valid(ov[0]), .out_ready(ordy[0]), .busy(bz[0])
    );
    neuron_mac_seq #(.N_INPUTS(8), .LUT_AW(10), .Z_RANGE_LOG2(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .bias(bias[1]), .act_bypass(byp[1]),
        .in_valid(iv[1]), .in_ready(ir[1]), .x(xv[1]), .w(wv[1]), .lut_addr(la1),
        .lut_data(ld[1]), .y(y1), .out_valid(ov[1]), .out_ready(ordy[1]), .busy(bz[1])
    );
    neuron_mac_seq #(.N_INPUTS(1), .LUT_AW(11), .Z_RANGE_LOG2(3)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .bias(bias[2]), .act_bypass(byp[2]),
        .in_valid(iv[2]), .in_ready(ir[2]), .x(xv[2]), .w(wv[2]), .lut_addr(la2),
        .lut_data(ld[2]), .y(y2), .out_valid(ov[2]), .out_ready(ordy[2]), .busy(bz[2])
    );

    // Arbitrary but deterministic stand-in for the sigmoid ROM contents.
    function automatic logic [16:0] rom(input int a);
        int t;
        t = a * 97 + 13;
        return 17'(t ^ (a << 5));
    endfunction

    always @(posedge clk) begin
        ld[0] <= rom(int'(la0));
        ld[1] <= rom(int'(la1));
        ld[2] <= rom(int'(la2));
    end

    function automatic int nin(input int i);
        case (i) 0: return 4; 1: return 8; default: return 1; endcase
    endfunction
    function automatic int law(input int i);
        return (i == 1) ? 10 : 11;
    endfunction
    function automatic int zr(input int i);
        return (i == 1) ? 4 : 3;
    endfunction
    function automatic int get_la(input int i);
        case (i) 0: return int'(la0); 1: return int'(la1); default: return int'(la2); endcase
    endfunction
    function automatic int get_y(input int i);
        case (i) 0: return int'(y0); 1: return int'(y1); default: return int'(y2); endcase
    endfunction
    function automatic int find_exp(input int i);
        foreach (sb[k]) if (sb[k].dut == i) return k;
        return -1;
    endfunction

    task automatic chk(input string nm, input int i, input longint act, input longint exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", nm, i, act, exp, $time);
        end
    endtask

    task automatic model(input int i, input logic [16:0] b, input logic bp,
                         output int ey, output int ea);
        longint z, a, yb, amax;
        int sh;
        z = longint'($signed(b)) * 65536;
        for (int k = 0; k < nin(i); k++)
            z += longint'($signed(xa[k])) * longint'($signed(wa[k]));
        sh   = 28 + zr(i) - (law(i) - 1);
        amax = (longint'(1) << law(i)) - 1;
        a    = (longint'(1) << (law(i) - 1)) + (z >>> sh);
        if (a < 0) a = 0;
        if (a > amax) a = amax;
        yb = z >>> 16;
        if (yb > 65535) yb = 65535;
        if (yb < -65536) yb = -65536;
        ea = int'(a);
        ey = bp ? int'(yb & 64'h1FFFF) : int'(rom(ea));
    endtask

    task automatic fill(input logic [16:0] xs, input logic [16:0] ws);
        for (int k = 0; k < 8; k++) begin
            xa[k] = xs;
            wa[k] = ws;
        end
    endtask

    task automatic run(input int i, input logic [16:0] b, input logic bp,
                       input int gap, input int hold);
        int to;
        exp_t e;
        to = 0;
        @(negedge clk);
        while (bz[i] && to < 300) begin
            @(negedge clk);
            to++;
        end
        if (bz[i]) begin
            chk("idle_timeout", i, 1, 0);
            return;
        end
        e.dut  = i;
        e.hold = hold;
        model(i, b, bp, e.y, e.addr);
        st[i] = 1'b1; bias[i] = b; byp[i] = bp;
        @(negedge clk);
        st[i] = 1'b0; bias[i] = 17'($urandom); byp[i] = ~bp;
        for (int k = 0; k < nin(i); k++) begin
            if (gap != 0 && k > 0) begin
                iv[i] = 1'b0; xv[i] = 17'($urandom); st[i] = 1'b1;
                @(negedge clk);
                st[i] = 1'b0;
            end
            iv[i] = 1'b1; xv[i] = xa[k]; wv[i] = wa[k];
            to = 0;
            while (!ir[i] && to < 50) begin
                @(negedge clk);
                to++;
            end
            if (!ir[i]) begin
                chk("ready_timeout", i, 1, 0);
                iv[i] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        iv[i] = 1'b0;
        e.lastcyc = cyc;
        sb.push_back(e);
        if (gap != 0) begin
            iv[i] = 1'b1; st[i] = 1'b1; xv[i] = 17'($urandom); wv[i] = 17'($urandom);
            @(negedge clk);
            iv[i] = 1'b0; st[i] = 1'b0;
        end
    endtask

    task automatic wait_done(input int i);
        int to;
        int n;
        to = 0;
        forever begin
            n = 0;
            foreach (sb[k]) if (sb[k].dut == i) n++;
            if ((n == 0 && !bz[i]) || to >= 300) break;
            @(negedge clk);
            to++;
        end
        if (to >= 300) chk("done_timeout", i, 1, 0);
    endtask

    // Monitor: compares every presented output against the scoreboard head for that instance.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < ND; i++) begin
                if (fall_chk[i]) begin
                    fall_chk[i] = 1'b0;
                    chk("fall_valid_busy", i, longint'({ov[i], bz[i]}), 0);
                end
                if (ov[i]) begin
                    mon_k = find_exp(i);
                    if (mon_k < 0) begin
                        chk("spurious_out", i, 1, 0);
                        ordy[i] = 1'b1;
                    end else begin
                        if (!prev_ov[i]) begin
                            chk("latency", i, cyc - sb[mon_k].lastcyc, 5);
                            hold_cnt[i] = sb[mon_k].hold;
                        end
                        chk("y", i, get_y(i), sb[mon_k].y);
                        chk("lut_addr", i, get_la(i), sb[mon_k].addr);
                        if (hold_cnt[i] > 0) begin
                            ordy[i] = 1'b0;
                            hold_cnt[i]--;
                        end else begin
                            ordy[i] = 1'b1;
                            sb.delete(mon_k);
                            fall_chk[i] = 1'b1;
                        end
                    end
                end else begin
                    ordy[i] = 1'b0;
                end
                prev_ov[i] = ov[i];
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        nerr++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < ND; i++) begin
            st[i] = 1'b0; bias[i] = '0; byp[i] = 1'b0; iv[i] = 1'b0; xv[i] = '0; wv[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 0, ir[0], 0);
        chk("rst_out_valid", 0, ov[0], 0);
        chk("rst_busy", 0, bz[0], 0);
        chk("rst_y", 0, y0, 0);
        chk("rst_lut_addr", 0, la0, 1024);
        chk("rst_lut_addr", 1, la1, 512);
        rst_n = 1'b1;
        @(negedge clk);

        fill(17'h08000, 17'd4096);
        run(0, 17'd0, 1'b0, 0, 0); wait_done(0);
        chk("z2_addr", 0, la0, 1280);
        chk("z2_sig_y", 0, y0, rom(1280));
        run(0, 17'd0, 1'b1, 0, 0); wait_done(0);
        chk("z2_byp_y", 0, y0, 8192);

        fill(17'h00000, 17'd4096);
        run(0, 17'd4096, 1'b1, 0, 0); wait_done(0);
        chk("bias_byp_y", 0, y0, 4096);
        chk("bias_addr", 0, la0, 1152);

        fill(17'h08000, 17'h18000);
        run(0, 17'd0, 1'b0, 0, 0); wait_done(0);
        chk("satneg_addr", 0, la0, 0);
        run(0, 17'd0, 1'b1, 0, 0); wait_done(0);
        chk("satneg_y", 0, y0, 17'h10000);

        fill(17'h0FFFF, 17'h07FFF);
        run(0, 17'd32767, 1'b0, 0, 0); wait_done(0);
        chk("satpos_addr", 0, la0, 2047);
        run(0, 17'd32767, 1'b1, 0, 0); wait_done(0);
        chk("satpos_y", 0, y0, 65535);

        fill(17'h08000, 17'd4096);
        run(0, 17'd0, 1'b0, 1, 3); wait_done(0);
        chk("gap_hold_y", 0, y0, rom(1280));

        // Abort after two of four beats.
        @(negedge clk);
        st[0] = 1'b1; bias[0] = 17'd4096; byp[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            iv[0] = 1'b1; xv[0] = 17'h08000; wv[0] = 17'd4096;
            @(negedge clk);
        end
        iv[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 0, ir[0], 0);
        chk("abort_out_valid", 0, ov[0], 0);
        chk("abort_busy", 0, bz[0], 0);
        chk("abort_y", 0, y0, 0);
        chk("abort_lut_addr", 0, la0, 1024);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 17'd0, 1'b0, 0, 0); wait_done(0);
        chk("post_abort_addr", 0, la0, 1280);

        fill(17'h00000, 17'd0);
        run(1, 17'd4096, 1'b0, 0, 0); wait_done(1);
        chk("n8_z1_addr", 1, la1, 544);
        fill(17'h08000, 17'd4096);
        run(1, 17'd0, 1'b0, 1, 0); wait_done(1);
        chk("n8_z4_addr", 1, la1, 640);
        run(2, 17'd0, 1'b0, 0, 2); wait_done(2);
        chk("n1_addr", 2, la2, 1088);
        run(2, 17'd0, 1'b1, 0, 0); wait_done(2);
        chk("n1_byp_y", 2, y2, 2048);

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < ND; i++) begin
                for (int k = 0; k < 8; k++) begin
                    xa[k] = 17'($urandom);
                    wa[k] = ($urandom_range(0, 3) == 0) ? 17'($urandom)
                                                       : 17'($urandom_range(0, 16383)) - 17'd8192;
                end
                run(i, 17'($urandom), 1'($urandom), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)));
            end
        end
        for (int i = 0; i < ND; i++) wait_done(i);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
